program_memory: RTL and testbench

Writable, parametrised instruction memory for the PucCPU fetch path. It replaces the fixed combinational program table with a synchronous-read RAM. A valid/ready loader port streams a program in while the core is stalled. After reset the block clears every word to the all-zero instruction before the core may fetch.

---
 rtl/program_memory_pkg.sv | 26 ++
 rtl/imem_ram.sv | 33 +++
 rtl/program_memory.sv | 148 ++++++++++++++
 tb/tb_program_memory.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// ---------------------------------------------------------------------------
// program_memory_pkg
// Shared definitions for the PucCPU instruction memory: default fetch/word
// widths, opcode encodings, the loader FSM state type and the NOP word.
// Instruction format is {4-bit opcode, 8-bit operand}.
// ---------------------------------------------------------------------------
package program_memory_pkg;

    localparam int PC_WIDTH          = 4;
    localparam int INSTRUCTION_WIDTH = 12;

    localparam logic [3:0] LOADI = 4'h1;
    localparam logic [3:0] MOVE  = 4'h2;
    localparam logic [3:0] ADD   = 4'h3;
    localparam logic [3:0] JUMP  = 4'h4;
    localparam logic [3:0] RESET = 4'h5;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP = '0;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// Single-port synchronous RAM, DEPTH x DATA_WIDTH. The read port registers
// the word at addr every cycle; a write stores wdata at addr on the same edge.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   ADDR_WIDTH word address
//   wdata  in   DATA_WIDTH write data
//   rdata  out  DATA_WIDTH registered read data
// ---------------------------------------------------------------------------
module imem_ram #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/program_memory.sv
// ---------------------------------------------------------------------------
// program_memory
// Writable instruction memory for the PucCPU fetch path. After reset every
// word is cleared to NOP, then the core may fetch with one-cycle latency.
// A valid/ready loader streams a program in while busy stalls the core.
// Ports:
//   clk                in   clock
//   reset              in   synchronous active-high reset
//   pc                 in   fetch address
//   fetch              in   fetch request for pc
//   instruction        out  fetch data (holds when no fetch completes)
//   instruction_valid  out  instruction belongs to last cycle's fetch
//   busy               out  high while clearing or loading
//   load_valid         in   loader word present
//   load_data          in   loader word
//   load_last          in   final word of a program
//   load_ready         out  loader word accepted this cycle when valid
//   load_done          out  one-cycle pulse after the final word is written
// ---------------------------------------------------------------------------
module program_memory #(
    parameter int PC_WIDTH          = program_memory_pkg::PC_WIDTH,
    parameter int INSTRUCTION_WIDTH = program_memory_pkg::INSTRUCTION_WIDTH,
    parameter int DEPTH             = 2**PC_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PC_WIDTH-1:0]          pc,
    input  logic                         fetch,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         instruction_valid,
    output logic                         busy,
    input  logic                         load_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         load_done
);

    import program_memory_pkg::*;

    localparam logic [PC_WIDTH-1:0] LAST_ADDR = PC_WIDTH'(DEPTH - 1);

    state_t                         state, state_next;
    logic [PC_WIDTH-1:0]            wptr, wptr_next;
    logic                           load_end;
    logic                           we;
    logic [PC_WIDTH-1:0]            addr;
    logic [INSTRUCTION_WIDTH-1:0]   wdata, rdata;
    logic                           fetch_ok, pc_oob;
    logic                           fetch_q, oob_q;
    logic [INSTRUCTION_WIDTH-1:0]   instr_hold;

    assign pc_oob = {1'b0, pc} >= (PC_WIDTH + 1)'(DEPTH);

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            wptr       <= '0;
            fetch_q    <= 1'b0;
            oob_q      <= 1'b0;
            load_done  <= 1'b0;
            instr_hold <= '0;
        end else begin
            state     <= state_next;
            wptr      <= wptr_next;
            fetch_q   <= fetch_ok;
            load_done <= load_end;
            if (fetch_ok) begin
                oob_q <= pc_oob;
            end
            // Remember the delivered word so the output holds between fetches.
            if (fetch_q) begin
                instr_hold <= instruction;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        wptr_next  = wptr;
        load_end   = 1'b0;
        unique case (state)
            CLEAR: begin
                if (wptr == LAST_ADDR) begin
                    state_next = RUN;
                    wptr_next  = '0;
                end else begin
                    wptr_next = wptr + 1'b1;
                end
            end
            RUN: begin
                // A load word wins over a fetch in the same cycle.
                if (load_valid) begin
                    if (load_last) begin
                        wptr_next = '0;
                        load_end  = 1'b1;
                    end else begin
                        state_next = LOAD;
                        wptr_next  = wptr + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (load_valid) begin
                    if (load_last || (wptr == LAST_ADDR)) begin
                        state_next = RUN;
                        wptr_next  = '0;
                        load_end   = 1'b1;
                    end else begin
                        wptr_next = wptr + 1'b1;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
                wptr_next  = '0;
            end
        endcase
    end

    // Output / datapath decode
    always_comb begin
        busy       = (state != RUN);
        load_ready = (state != CLEAR);
        we         = (state == CLEAR) || (load_ready && load_valid);
        wdata      = (state == CLEAR) ? NOP : load_data;
        addr       = we ? wptr : pc;
        fetch_ok   = (state == RUN) && fetch && !load_valid;
    end

    assign instruction_valid = fetch_q;
    assign instruction       = fetch_q ? (oob_q ? NOP : rdata) : instr_hold;

    imem_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PC_WIDTH),
        .DATA_WIDTH (INSTRUCTION_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_program_memory.sv
module tb_program_memory;
    import program_memory_pkg::*;

    localparam int D1 = 16;
    localparam int D2 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, DEPTH = 16
    logic        reset = 1'b1, fetch = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [3:0]  pc = '0;
    logic [11:0] load_data = '0;
    logic [11:0] instruction;
    logic        instruction_valid, busy, load_ready, load_done;

    // Second DUT, DEPTH = 10
    logic        reset2 = 1'b1, fetch2 = 1'b0, load_valid2 = 1'b0, load_last2 = 1'b0;
    logic [3:0]  pc2 = '0;
    logic [11:0] load_data2 = '0;
    logic [11:0] instruction2;
    logic        instruction_valid2, busy2, load_ready2, load_done2;

    program_memory #(.PC_WIDTH(4), .INSTRUCTION_WIDTH(12), .DEPTH(D1)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch(fetch),
        .instruction(instruction), .instruction_valid(instruction_valid),
        .busy(busy), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done)
    );

    program_memory #(.PC_WIDTH(4), .INSTRUCTION_WIDTH(12), .DEPTH(D2)) dut2 (
        .clk(clk), .reset(reset2), .pc(pc2), .fetch(fetch2),
        .instruction(instruction2), .instruction_valid(instruction_valid2),
        .busy(busy2), .load_valid(load_valid2), .load_data(load_data2),
        .load_last(load_last2), .load_ready(load_ready2), .load_done(load_done2)
    );

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model of the main DUT: memory contents, clear countdown,
    // and whether a multi-word load is in progress.
    logic [11:0] mmem [D1];
    int          clear_left = 0;
    bit          loading = 1'b0;
    int          wp = 0;
    bit          armed = 1'b0;
    logic        e_valid = 1'b0, e_done = 1'b0;
    logic [11:0] e_instr = '0;

    always @(posedge clk) begin
        if (reset) begin
            clear_left = D1; loading = 1'b0; wp = 0;
            e_valid = 1'b0; e_done = 1'b0; e_instr = '0; armed = 1'b1;
        end else begin
            e_valid = 1'b0;
            e_done  = 1'b0;
            if (clear_left > 0) begin
                mmem[D1 - clear_left] = '0;
                clear_left--;
            end else if (load_valid) begin
                mmem[wp] = load_data;
                wp++;
                if (load_last || wp == D1) begin
                    wp = 0; loading = 1'b0; e_done = 1'b1;
                end else begin
                    loading = 1'b1;
                end
            end else if (fetch && !loading) begin
                e_valid = 1'b1;
                e_instr = (int'(pc) < D1) ? mmem[pc] : '0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m_valid", instruction_valid, e_valid);
            check("m_instr", instruction, e_instr);
            check("m_busy", busy, (clear_left > 0) || loading);
            check("m_ready", load_ready, clear_left == 0);
            check("m_done", load_done, e_done);
            if (load_done) done_cnt++;
        end
    end

    task automatic step(input bit r, input bit lv, input bit ll, input bit f,
                        input logic [3:0] p, input logic [11:0] d);
        reset = r; load_valid = lv; load_last = ll; fetch = f; pc = p; load_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
    endtask

    task automatic step2(input bit r, input bit lv, input bit ll, input bit f,
                         input logic [3:0] p, input logic [11:0] d);
        reset2 = r; load_valid2 = lv; load_last2 = ll; fetch2 = f; pc2 = p; load_data2 = d;
        @(posedge clk); #1;
    endtask

    // Counts busy cycles from now until busy drops, bounded.
    task automatic clear_len(input string name, input int exp);
        int n = 0;
        while (busy && n < 60) begin
            n++;
            idle();
        end
        check(name, n, exp);
    endtask

    logic [11:0] prog [8];

    initial begin
        int d0, n;
        logic [11:0] w;
        prog[0] = {LOADI, 8'd3}; prog[1] = {MOVE, 8'd0}; prog[2] = {LOADI, 8'd1};
        prog[3] = {ADD, 8'd0};   prog[4] = {JUMP, 8'd4}; prog[5] = {LOADI, 8'd1};
        prog[6] = {ADD, 8'd0};   prog[7] = {RESET, 8'd0};

        // Reset and clear
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        check("rst_valid", instruction_valid, 1'b0);
        check("rst_done", load_done, 1'b0);
        check("rst_ready", load_ready, 1'b0);
        reset = 1'b0;
        clear_len("clear_len", 16);
        for (int i = 0; i < D1; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 12'd0);
            check("clr_valid", instruction_valid, 1'b1);
            check("clr_word", instruction, 12'h000);
        end

        // Back-to-back program load
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i == 7, 1'b0, 4'd0, prog[i]);
        check("prog_done_now", load_done, 1'b1);
        check("prog_busy_low", busy, 1'b0);
        idle();
        check("prog_done_once", done_cnt - d0, 1);
        for (int i = 0; i < D1; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 12'd0);
            check("prog_word", instruction, (i < 8) ? prog[i] : 12'h000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 12'd0);
        check("pin_jump", instruction, 12'h404);
        idle();
        check("hold_valid", instruction_valid, 1'b0);
        check("hold_word", instruction, 12'h404);

        // Same load with gaps
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, i == 7, 1'b0, 4'd0, prog[i]);
            if (i < 7) begin
                n = $urandom_range(1, 3);
                for (int g = 0; g < n; g++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 12'd0);
                    check("gap_busy", busy, 1'b1);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 12'd0);
            check("gap_word", instruction, prog[i]);
        end

        // 20 words; the first 16 end on depth, word 17 restarts at 0
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, k == 20, 1'b0, 4'd0, 12'hA00 + 12'(k));
            if (k == 16) begin
                check("depth_end_busy", busy, 1'b0);
                check("depth_end_done", load_done, 1'b1);
                check("depth_end_ready", load_ready, 1'b1);
            end
            if (k == 17) check("restart_busy", busy, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 12'd0);
        check("restart_w0", instruction, 12'hA11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 12'd0);
        check("restart_w3", instruction, 12'hA14);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 12'd0);
        check("kept_w4", instruction, 12'hA05);

        // Fetch collides with a single-word load
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 12'h777);
        check("coll_valid", instruction_valid, 1'b0);
        check("coll_done", load_done, 1'b1);
        check("coll_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 12'd0);
        check("single_w0", instruction, 12'h777);

        // Reset mid-load
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, prog[i]);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        reset = 1'b0;
        clear_len("abort_clear_len", 16);
        check("abort_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 12'd0);
            check("abort_word", instruction, 12'h000);
        end

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), 12'($urandom));
        end
        idle();

        // DEPTH = 10 instance
        step2(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        reset2 = 1'b0;
        n = 0;
        while (busy2 && n < 60) begin
            n++;
            step2(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        end
        check("d10_clear_len", n, 10);
        for (int i = 0; i < D2; i++) step2(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 12'hB00 + 12'(i));
        check("d10_done", load_done2, 1'b1);
        check("d10_busy", busy2, 1'b0);
        step2(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 12'd0);
        check("d10_pc12_valid", instruction_valid2, 1'b1);
        check("d10_pc12", instruction2, 12'h000);
        step2(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 12'd0);
        check("d10_pc9", instruction2, 12'hB09);
        step2(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 12'd0);
        check("d10_pc15", instruction2, 12'h000);
        w = instruction2;
        step2(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        check("d10_hold", instruction2, w);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
